// File: rtl/sec_enc_pkg.sv
// SEC Hamming column generator, check-bit masks and width derivation, shared by encoder and decoder.
// SEC_ENC_DED_EN adds an overall-parity bit at cw_data[R] (SEC-DED).
package sec_enc_pkg;

`ifdef SEC_ENC_DED_EN
   localparam bit DED_EN = 1'b1;
`else
   localparam bit DED_EN = 1'b0;
`endif

   localparam int MAX_K      = 1024;
   localparam int K_DEF      = 128;
   localparam int R_DEF      = 8;
   localparam int BEAT_W_DEF = 32;

   // Column j is the j-th R-bit value that is neither zero nor a power of two.
   function automatic int h_col(input int j, input int r);
      int cnt;
      int col;
      cnt = 0;
      col = 0;
      for (int v = 3; v < (1 << r); v++) begin
         if ((v & (v - 1)) != 0) begin
            if (cnt == j) col = v;
            cnt++;
         end
      end
      return col;
   endfunction

   // Same column enumeration as h_col, walked once so the whole mask costs 2**R steps.
   function automatic logic [MAX_K-1:0] par_mask(input int r, input int k, input int rb);
      logic [MAX_K-1:0] m;
      int               j;
      m = '0;
      j = 0;
      for (int v = 3; v < (1 << rb); v++) begin
         if (((v & (v - 1)) != 0) && (j < k)) begin
            m[j] = v[r];
            j++;
         end
      end
      return m;
   endfunction

   function automatic int calc_beats(input int k, input int bw);
      return k / bw;
   endfunction

   function automatic int calc_n(input int k, input int r);
      return k + r + (DED_EN ? 1 : 0);
   endfunction

   localparam int BEATS_DEF = calc_beats(K_DEF, BEAT_W_DEF);
   localparam int N_DEF     = calc_n(K_DEF, R_DEF);

endpackage

// File: rtl/sec_beat_encoder_if.sv
// Beat input and codeword output channels of the SEC beat encoder; master is the producer/consumer side.
interface sec_beat_encoder_if
   import sec_enc_pkg::*;
#(
   parameter int BEAT_W = BEAT_W_DEF,
   parameter int N      = N_DEF
) ();

   logic              in_valid;
   logic              in_ready;
   logic [BEAT_W-1:0] in_data;
   logic              in_last;
   logic              cw_valid;
   logic              cw_ready;
   logic [N-1:0]      cw_data;
   logic              err_frame;

   modport master (
      output in_valid, in_data, in_last, cw_ready,
      input  in_ready, cw_valid, cw_data, err_frame
   );

   modport slave (
      input  in_valid, in_data, in_last, cw_ready,
      output in_ready, cw_valid, cw_data, err_frame
   );

endinterface

// File: rtl/sec_beat_parity.sv
// Combinational partial SEC parity of one beat, selected by beat index; zero latency, no flow control.
module sec_beat_parity
   import sec_enc_pkg::*;
#(
   parameter int K      = K_DEF,
   parameter int R      = R_DEF,
   parameter int BEAT_W = BEAT_W_DEF,
   parameter int IDX_W  = (calc_beats(K, BEAT_W) > 1) ? $clog2(calc_beats(K, BEAT_W)) : 1
) (
   input  logic [BEAT_W-1:0] beat_data,
   input  logic [IDX_W-1:0]  beat_idx,
   output logic [R-1:0]      partial
);

   localparam int BEATS = calc_beats(K, BEAT_W);

   logic [BEATS-1:0][R-1:0] beat_par;

   for (genvar r = 0; r < R; r++) begin : g_row
      localparam logic [MAX_K-1:0] MASK = par_mask(r, K, R);
      for (genvar b = 0; b < BEATS; b++) begin : g_beat
         assign beat_par[b][r] = ^(beat_data & MASK[b*BEAT_W +: BEAT_W]);
      end
   end

   always_comb begin
      partial = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (beat_idx == IDX_W'(b)) partial = beat_par[b];
      end
   end

endmodule

// File: rtl/sec_beat_encoder.sv
// Beat-serial SEC encoder: codeword valid 1 cycle after last-beat accept; only the last beat stalls on a full output.
// SEC_ENC_DED_EN appends overall even parity at cw_data[R].
module sec_beat_encoder
   import sec_enc_pkg::*;
#(
   parameter int K      = K_DEF,
   parameter int R      = R_DEF,
   parameter int BEAT_W = BEAT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   sec_beat_encoder_if.slave bus
);

   localparam int BEATS = calc_beats(K, BEAT_W);
   localparam int N     = calc_n(K, R);
   localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

   if (((1 << R) - 1 - R) < K) begin : g_r_too_small
      $error("sec_beat_encoder: R=%0d check bits cannot cover K=%0d", R, K);
   end
   if ((K % BEAT_W) != 0 || K > MAX_K) begin : g_bad_k
      $error("sec_beat_encoder: K=%0d must be a multiple of BEAT_W=%0d and <= %0d", K, BEAT_W, MAX_K);
   end

   logic [IDX_W-1:0] beat_cnt;
   logic [K-1:0]     msg_buf;
   logic [K-1:0]     msg_full;
   logic [R-1:0]     par_acc;
   logic [R-1:0]     partial;
   logic [R-1:0]     par_full;
   logic [N-1:0]     cw_next;
   logic             at_last;
   logic             accept;

   assign at_last      = (beat_cnt == LAST_IDX);
   assign bus.in_ready = !at_last || !bus.cw_valid || bus.cw_ready;
   assign accept       = bus.in_valid && bus.in_ready;

   sec_beat_parity #(
      .K      (K),
      .R      (R),
      .BEAT_W (BEAT_W),
      .IDX_W  (IDX_W)
   ) u_parity (
      .beat_data (bus.in_data),
      .beat_idx  (beat_cnt),
      .partial   (partial)
   );

   // Beat 0 loads, so a discarded or reset-interrupted word never leaks into the next.
   assign par_full = (beat_cnt == '0) ? partial : (par_acc ^ partial);

   always_comb begin
      msg_full = msg_buf;
      for (int b = 0; b < BEATS; b++) begin
         if (beat_cnt == IDX_W'(b)) msg_full[b*BEAT_W +: BEAT_W] = bus.in_data;
      end
   end

`ifdef SEC_ENC_DED_EN
   assign cw_next = {msg_full, ^{msg_full, par_full}, par_full};
`else
   assign cw_next = {msg_full, par_full};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt      <= '0;
         msg_buf       <= '0;
         par_acc       <= '0;
         bus.cw_valid  <= 1'b0;
         bus.cw_data   <= '0;
         bus.err_frame <= 1'b0;
      end else begin
         bus.err_frame <= 1'b0;
         if (bus.cw_valid && bus.cw_ready) bus.cw_valid <= 1'b0;
         if (accept) begin
            if (at_last) begin
               // Word is emitted even without in_last; the framing error is only flagged.
               bus.cw_data   <= cw_next;
               bus.cw_valid  <= 1'b1;
               beat_cnt      <= '0;
               bus.err_frame <= !bus.in_last;
            end else if (bus.in_last) begin
               beat_cnt      <= '0;
               par_acc       <= '0;
               bus.err_frame <= 1'b1;
            end else begin
               msg_buf  <= msg_full;
               par_acc  <= par_full;
               beat_cnt <= beat_cnt + IDX_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sec_beat_encoder.sv
// Self-checking bench for sec_beat_encoder: vector table, stall/framing/reset sequences, single-bit sweep.
module tb_sec_beat_encoder;
   import sec_enc_pkg::*;

   localparam int K      = 128;
   localparam int R      = 8;
   localparam int BEAT_W = 32;
   localparam int BEATS  = K / BEAT_W;
   localparam int N      = calc_n(K, R);

   typedef logic [K-1:0] msg_t;
   typedef logic [N-1:0] cw_t;

   typedef struct {
      msg_t         msg;
      logic [R-1:0] par;
      logic         ded;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   err_seen = 0;
   cw_t  exp_q[$];
   cw_t  last_cw = '0;
   logic [R-1:0] cols [K];
   bit   seen [256];
   vec_t vecs [6];

   always #5 clk = ~clk;

   sec_beat_encoder_if #(.BEAT_W(BEAT_W), .N(N)) bif ();

   sec_beat_encoder #(.K(K), .R(R), .BEAT_W(BEAT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   task automatic check(input string name, input cw_t act, input cw_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      check(name, cw_t'(act), cw_t'(exp));
   endtask

   task automatic fail(input string name, input string what);
      checks++;
      failures++;
      $display("FAIL %s %s", name, what);
   endtask

   function automatic logic [R-1:0] tb_col(input int j);
      int v = 0;
      int n = -1;
      while (n < j) begin
         v++;
         if ($countones(v) > 1) n++;
      end
      return v[R-1:0];
   endfunction

   function automatic logic [R-1:0] ref_par(input msg_t m);
      logic [R-1:0] p = '0;
      for (int j = 0; j < K; j++) if (m[j]) p ^= cols[j];
      return p;
   endfunction

   function automatic cw_t build(input msg_t m, input logic [R-1:0] p, input logic d);
      cw_t w = '0;
      w[N-1 -: K] = m;
      w[R-1:0]    = p;
      if (DED_EN) w[R] = d;
      return w;
   endfunction

   function automatic cw_t model(input msg_t m);
      logic [R-1:0] p = ref_par(m);
      return build(m, p, ^{m, p});
   endfunction

   function automatic msg_t onehot(input int j);
      msg_t m = '0;
      m[j] = 1'b1;
      return m;
   endfunction

   function automatic msg_t rand_msg();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic send_beat(input logic [BEAT_W-1:0] d, input logic last);
      bit done = 0;
      @(negedge clk);
      bif.in_valid = 1'b1;
      bif.in_data  = d;
      bif.in_last  = last;
      for (int i = 0; i < 200 && !done; i++) begin
         #1;
         if (bif.in_ready) begin
            @(posedge clk);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) fail("beat_accept", "timeout waiting for in_ready");
   endtask

   task automatic send_word(input msg_t m, input bit good_last);
      for (int b = 0; b < BEATS; b++)
         send_beat(m[b*BEAT_W +: BEAT_W], (b == BEATS - 1) ? good_last : 1'b0);
   endtask

   task automatic idle();
      @(negedge clk);
      bif.in_valid = 1'b0;
      bif.in_last  = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) fail("drain", "timeout waiting for codeword");
   endtask

   // Scoreboard: while a codeword is presented it must equal the queue head every cycle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (bif.err_frame) err_seen++;
         if (bif.cw_valid) begin
            if (exp_q.size() == 0) begin
               fail("cw_unexpected", $sformatf("actual=%0h required=none", bif.cw_data));
            end else begin
               check("cw_data", bif.cw_data, exp_q[0]);
               if (bif.cw_ready) begin
                  last_cw = bif.cw_data;
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      msg_t a, b, c, d, p, q;
      int   err_base;

      for (int j = 0; j < K; j++) cols[j] = tb_col(j);
      vecs[0] = '{msg: '0,          par: 8'h00, ded: 1'b0};
      vecs[1] = '{msg: onehot(0),   par: 8'h03, ded: 1'b1};
      vecs[2] = '{msg: onehot(1),   par: 8'h05, ded: 1'b1};
      vecs[3] = '{msg: onehot(2),   par: 8'h06, ded: 1'b1};
      vecs[4] = '{msg: onehot(3),   par: 8'h07, ded: 1'b0};
      vecs[5] = '{msg: onehot(127), par: 8'h88, ded: 1'b1};

      bif.in_valid = 1'b0;
      bif.in_data  = '0;
      bif.in_last  = 1'b0;
      bif.cw_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check1("rst_cw_valid", bif.cw_valid, 1'b0);
      check("rst_cw_data", bif.cw_data, '0);
      check1("rst_err_frame", bif.err_frame, 1'b0);
      check1("rst_in_ready", bif.in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;

      // Table of fixed messages with hand-derived parity.
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(build(vecs[i].msg, vecs[i].par, vecs[i].ded));
         send_word(vecs[i].msg, 1'b1);
         idle();
         #1;
         check1("cw_latency", bif.cw_valid, 1'b1);
         drain();
      end

      // Output stalled for 10 cycles: next word's first beats flow, its last beat waits.
      a = rand_msg(); b = rand_msg(); c = rand_msg(); d = rand_msg();
      @(negedge clk);
      bif.cw_ready = 1'b0;
      fork
         begin
            repeat (10) @(negedge clk);
            bif.cw_ready = 1'b1;
         end
      join_none
      exp_q.push_back(model(a));
      send_word(a, 1'b1);
      exp_q.push_back(model(b));
      for (int i = 0; i < BEATS - 1; i++) send_beat(b[i*BEAT_W +: BEAT_W], 1'b0);
      idle();
      #1;
      check1("stall_in_ready", bif.in_ready, 1'b0);
      check1("stall_cw_valid", bif.cw_valid, 1'b1);
      send_beat(b[K-1 -: BEAT_W], 1'b1);
      exp_q.push_back(model(c));
      send_word(c, 1'b1);
      exp_q.push_back(model(d));
      send_word(d, 1'b1);
      idle();
      drain();

      // Framing errors.
      err_base = err_seen;
      a = rand_msg();
      send_beat(a[BEAT_W-1:0], 1'b0);
      send_beat(a[2*BEAT_W-1:BEAT_W], 1'b1);
      idle();
      #1;
      check1("err_short_pulse", bif.err_frame, 1'b1);
      check1("err_short_drop", bif.cw_valid, 1'b0);
      b = rand_msg();
      exp_q.push_back(model(b));
      send_word(b, 1'b1);
      idle();
      #1;
      check1("err_clean_none", bif.err_frame, 1'b0);
      drain();
      c = rand_msg();
      exp_q.push_back(model(c));
      send_word(c, 1'b0);
      idle();
      #1;
      check1("err_nolast_pulse", bif.err_frame, 1'b1);
      check1("err_nolast_cw", bif.cw_valid, 1'b1);
      drain();
      check("err_count", cw_t'(err_seen - err_base), cw_t'(2));

      // Reset mid-word with a stalled codeword pending.
      p = rand_msg(); q = rand_msg();
      @(negedge clk);
      bif.cw_ready = 1'b0;
      exp_q.push_back(model(p));
      send_word(p, 1'b1);
      for (int i = 0; i < 3; i++) send_beat(q[i*BEAT_W +: BEAT_W], 1'b0);
      idle();
      rst_n = 1'b0;
      #1;
      check1("mid_rst_cw_valid", bif.cw_valid, 1'b0);
      check("mid_rst_cw_data", bif.cw_data, '0);
      check1("mid_rst_err_frame", bif.err_frame, 1'b0);
      check1("mid_rst_in_ready", bif.in_ready, 1'b1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bif.cw_ready = 1'b1;
      q = rand_msg();
      exp_q.push_back(model(q));
      send_word(q, 1'b1);
      idle();
      drain();

      // Single-bit sweep: every syndrome nonzero, not a power of two, and unique.
      for (int j = 0; j < K; j++) begin
         logic [R-1:0] synd;
         logic         ok;
         exp_q.push_back(model(onehot(j)));
         send_word(onehot(j), 1'b1);
         idle();
         drain();
         synd = last_cw[R-1:0];
         ok = (synd != '0) && ((synd & (synd - 1'b1)) == '0 ? 1'b0 : 1'b1) && !seen[synd];
         seen[synd] = 1'b1;
         check1("sweep_syndrome_unique", ok, 1'b1);
      end

      check("err_total", cw_t'(err_seen), cw_t'(2));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
